// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   localparam int PC_W    = 64;
   localparam int IMEM_AW = 10;
   localparam int INSTR_W = 64;

   localparam logic [PC_W-1:0] RESET_PC = 64'h0;
   localparam logic [PC_W-1:0] PC_STEP  = 64'd4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   // Word address into instruction memory; wraps naturally at 2^IMEM_AW words.
   function automatic logic [IMEM_AW-1:0] pc_to_imem_addr(input logic [PC_W-1:0] pc);
      return IMEM_AW'(pc >> 2);
   endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with redirect / increment / hold selection.
module fetch_pc_gen
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load_redirect,
   input  logic               advance,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [PC_W-1:0]    pc,
   output logic [IMEM_AW-1:0] imem_addr
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   // Redirect wins over sequential advance; targets are forced word-aligned.
   always_comb begin
      pc_d = pc_q;
      if (load_redirect) begin
         pc_d = redirect_pc & ~PC_W'(3);
      end else if (advance) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   // PC register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_to_imem_addr(pc_q);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, registers the fetched instruction
// into the IF/ID slot and handles redirects from execute.
// Optional build macro IFU_PERF_CNT_EN adds saturating performance counters.
//
// state | meaning
// BOOT  | first edge after reset; memory settles on the reset address
// FETCH | slot may be refilled every cycle
// HOLD  | valid word waiting on decode; pc and slot frozen
module instruction_fetch_unit
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               id_ready,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall,
   output logic [31:0]        perf_flush
`endif
);

   fetch_state_t       state_q, state_d;
   logic               if_valid_q, if_valid_d;
   logic [INSTR_W-1:0] if_instr_q, if_instr_d;
   logic [PC_W-1:0]    if_pc_q, if_pc_d;

   logic               capture;
   logic               load_redirect;
   logic               slot_free;
   logic [PC_W-1:0]    pc;

   fetch_pc_gen u_pc_gen (
      .clk           (clk),
      .reset         (reset),
      .load_redirect (load_redirect),
      .advance       (capture),
      .redirect_pc   (redirect_pc),
      .pc            (pc),
      .imem_addr     (imem_addr)
   );

   assign slot_free = !if_valid_q || id_ready;

   // Next state, slot update and pc control; redirect outranks capture.
   always_comb begin
      state_d       = state_q;
      if_valid_d    = if_valid_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      capture       = 1'b0;
      load_redirect = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (redirect_valid) begin
               load_redirect = 1'b1;
               if_valid_d    = 1'b0;
               state_d       = FETCH;
            end else if (slot_free) begin
               capture = 1'b1;
               state_d = FETCH;
            end else begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               load_redirect = 1'b1;
               if_valid_d    = 1'b0;
               state_d       = FETCH;
            end else if (id_ready) begin
               capture = 1'b1;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      if (capture) begin
         if_instr_d = imem_instr;
         if_pc_d    = pc;
         if_valid_d = 1'b1;
      end
   end

   // State and IF/ID output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= BOOT;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
      end
   end

   assign if_valid = if_valid_q;
   assign if_instr = if_instr_q;
   assign if_pc    = if_pc_q;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   // Saturating event counters.
   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_stall_d   = perf_stall_q;
      perf_flush_d   = perf_flush_q;
      if (if_valid_q && id_ready && (perf_fetched_q != 32'hFFFF_FFFF)) begin
         perf_fetched_d = perf_fetched_q + 32'd1;
      end
      if (if_valid_q && !id_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (load_redirect && if_valid_q && (perf_flush_q != 32'hFFFF_FFFF)) begin
         perf_flush_d = perf_flush_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
         perf_flush_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
         perf_flush_q   <= perf_flush_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
   assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table plus randomized
// traffic against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  imem_addr;
   logic [63:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        id_ready = 1'b0;
   logic        if_valid;
   logic [63:0] if_instr;
   logic [63:0] if_pc;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

   logic [63:0] mem [0:1023];
   assign imem_instr = mem[imem_addr];

   always #5 clk = ~clk;

   instruction_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall),
      .perf_flush     (perf_flush)
`endif
   );

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: where the PC points, what the slot holds.
   bit          m_boot;
   bit          m_valid;
   logic [63:0] m_pc, m_instr, m_ipc;
   int          m_fetched, m_stall, m_flush;

   function automatic void model_reset();
      m_boot = 1'b1; m_valid = 1'b0;
      m_pc = 64'h0; m_instr = 64'h0; m_ipc = 64'h0;
      m_fetched = 0; m_stall = 0; m_flush = 0;
   endfunction

   function automatic void model_edge();
      if (m_valid && id_ready) m_fetched++;
      if (m_valid && !id_ready) m_stall++;
      if (!m_boot && redirect_valid && m_valid) m_flush++;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (redirect_valid) begin
         m_pc    = {redirect_pc[63:2], 2'b00};
         m_valid = 1'b0;
      end else if (!m_valid || id_ready) begin
         m_instr = mem[m_pc[11:2]];
         m_ipc   = m_pc;
         m_valid = 1'b1;
         m_pc    = m_pc + 64'd4;
      end
   endfunction

   task automatic check(input string name, input logic ev, input logic [63:0] ei,
                        input logic [63:0] ep, input logic [9:0] ea);
      bit bad = 1'b0;
      vectors++;
      if (if_valid !== ev) begin
         $display("FAIL %s if_valid got %0b want %0b", name, if_valid, ev); bad = 1'b1;
      end
      if (if_instr !== ei) begin
         $display("FAIL %s if_instr got %h want %h", name, if_instr, ei); bad = 1'b1;
      end
      if (if_pc !== ep) begin
         $display("FAIL %s if_pc got %h want %h", name, if_pc, ep); bad = 1'b1;
      end
      if (imem_addr !== ea) begin
         $display("FAIL %s imem_addr got %0d want %0d", name, imem_addr, ea); bad = 1'b1;
      end
      if (bad) miscompares++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Reset asserted between edges must clear the outputs without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      check("async_reset", 1'b0, 64'h0, 64'h0, 10'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      bit          rst_before;
      bit          rv;
      logic [63:0] rpc;
      bit          rdy;
      bit          e_valid;
      logic [63:0] e_instr;
      logic [63:0] e_pc;
      logic [9:0]  e_addr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit rv, logic [63:0] rpc, bit rdy, bit ev,
                               logic [63:0] ei, logic [63:0] ep, logic [9:0] ea);
      vec_t v;
      v.rst_before = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_addr = ea;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
      mem[0] = 64'd1; mem[1] = 64'd2; mem[2] = 64'd3;
      mem[10] = 64'hAA; mem[1023] = 64'd9;

      // streaming with id_ready held
      tbl.push_back(mk(1, 0, 64'h0, 1, 0, 64'h0, 64'h0, 10'd0));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd1, 64'h0, 10'd1));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd2, 64'h4, 10'd2));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd3, 64'h8, 10'd3));
      // back-pressure: three stall cycles after first capture
      tbl.push_back(mk(1, 0, 64'h0, 1, 0, 64'h0, 64'h0, 10'd0));
      tbl.push_back(mk(0, 0, 64'h0, 0, 1, 64'd1, 64'h0, 10'd1));
      tbl.push_back(mk(0, 0, 64'h0, 0, 1, 64'd1, 64'h0, 10'd1));
      tbl.push_back(mk(0, 0, 64'h0, 0, 1, 64'd1, 64'h0, 10'd1));
      tbl.push_back(mk(0, 0, 64'h0, 0, 1, 64'd1, 64'h0, 10'd1));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd2, 64'h4, 10'd2));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd3, 64'h8, 10'd3));
      tbl.push_back(mk(0, 0, 64'h0, 0, 1, 64'd3, 64'h8, 10'd3));
      // redirect while holding: misaligned target, word flushed
      tbl.push_back(mk(0, 1, 64'h2B, 0, 0, 64'd3, 64'h8, 10'd10));
      tbl.push_back(mk(0, 0, 64'h0, 0, 1, 64'hAA, 64'h28, 10'd11));
      // redirect while a transfer would happen, then address wrap
      tbl.push_back(mk(0, 1, 64'hFFC, 1, 0, 64'hAA, 64'h28, 10'd1023));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd9, 64'hFFC, 10'd0));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd1, 64'h1000, 10'd1));
      // full 64-bit pc wrap
      tbl.push_back(mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 64'd1, 64'h1000, 10'd1023));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd9, 64'hFFFF_FFFF_FFFF_FFFC, 10'd0));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd1, 64'h0, 10'd1));
      // redirect during BOOT is ignored
      tbl.push_back(mk(1, 1, 64'h40, 1, 0, 64'h0, 64'h0, 10'd0));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 64'd1, 64'h0, 10'd1));

      foreach (tbl[i]) begin
         if (tbl[i].rst_before) do_reset();
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         id_ready       = tbl[i].rdy;
         step();
         check($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_instr,
               tbl[i].e_pc, tbl[i].e_addr);
      end

      // enter HOLD, then async reset between edges (inside do_reset)
      redirect_valid = 1'b0;
      id_ready = 1'b0;
      step();
      check("hold_before_reset", 1'b1, 64'd1, 64'h0, 10'd1);
      do_reset();

`ifdef IFU_PERF_CNT_EN
      id_ready = 1'b1;
      step();                             // BOOT
      step();                             // first capture, no transfer yet
      for (int k = 0; k < 5; k++) step(); // 5 transfers
      id_ready = 1'b0;
      step(); step();                     // 2 stalls
      redirect_valid = 1'b1;
      redirect_pc = 64'h100;
      step();                             // stall + flush
      redirect_valid = 1'b0;
      vectors++;
      if (perf_fetched !== 32'd5 || perf_stall !== 32'd3 || perf_flush !== 32'd1) begin
         $display("FAIL perf_directed got %0d/%0d/%0d want 5/3/1",
                  perf_fetched, perf_stall, perf_flush);
         miscompares++;
      end
      do_reset();
`endif

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         redirect_valid = ($urandom_range(0, 7) == 0);
         redirect_pc    = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                                      : {52'h0, 12'($urandom)};
         id_ready       = ($urandom_range(0, 3) != 0);
         if (if_valid && id_ready) begin
            vectors++;
            if (if_instr !== mem[if_pc[11:2]]) begin
               $display("FAIL stream instr at pc %h got %h want %h",
                        if_pc, if_instr, mem[if_pc[11:2]]);
               miscompares++;
            end
         end
         step();
         check("rnd", m_valid, m_instr, m_ipc, m_pc[11:2]);
      end

`ifdef IFU_PERF_CNT_EN
      vectors++;
      if (perf_fetched !== 32'(m_fetched) || perf_stall !== 32'(m_stall) ||
          perf_flush !== 32'(m_flush)) begin
         $display("FAIL perf_random got %0d/%0d/%0d want %0d/%0d/%0d",
                  perf_fetched, perf_stall, perf_flush, m_fetched, m_stall, m_flush);
         miscompares++;
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
